bitmap_rect_writer: RTL

- Drawing engine that fills axis-aligned, solid-colour rectangles into the 320x240, 3-bit-per-pixel frame bitmap.
- Drives the bitmap's write port (x, y, color, wr_en) at one pixel per clock.
- Runs in the clk_vga domain; the bitmap's user-side write clock is tied to clk_vga.
- Game logic issues rectangle commands (paddles, ball, background clear) over a valid/ready handshake. Drawing can optionally be held off until vertical blanking to avoid tearing.

---
 rtl/bitmap_rect_writer_if.sv | 27 ++
 rtl/bitmap_rect_writer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bitmap_rect_writer_if.sv
// Command handshake plus bitmap write port of the rectangle writer.
// master = command issuer / bitmap side, slave = drawing engine.
interface bitmap_rect_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [8:0] cmd_x;
   logic [7:0] cmd_y;
   logic [8:0] cmd_w;
   logic [7:0] cmd_h;
   logic [2:0] cmd_color;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] color;
   logic       wr_en;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      input  cmd_ready, x, y, color, wr_en, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      output cmd_ready, x, y, color, wr_en, busy, done
   );
endinterface

// File: rtl/bitmap_rect_writer.sv
// Fills clipped solid rectangles into the frame bitmap, one pixel per clock, row-major.
// First write the cycle after accept (or after the vsync fall); commands offered while busy are dropped.
module bitmap_rect_writer #(
   parameter int SCREEN_W       = 320,
   parameter int SCREEN_H       = 240,
   parameter int SYNC_TO_VBLANK = 0
) (
   input  logic                 clk_vga,
   input  logic                 reset,
   input  logic                 vga_vsync,
   bitmap_rect_writer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT_VB, DRAW} state_t;

   localparam logic [9:0] W10 = 10'(SCREEN_W);
   localparam logic [8:0] H9  = 9'(SCREEN_H);

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d, xs_q, xs_d;
   logic [7:0] y_q, y_d, ys_q, ys_d;
   logic [2:0] color_q, color_d, col_q, col_d;
   logic [9:0] xe_q, xe_d;
   logic [8:0] ye_q, ye_d;
   logic       done_q, done_d;
   logic       vs_q, vs_prev_q;

   logic       accept, empty, vs_fall, last_col, last_row;
   logic [9:0] x_sum, x_clip;
   logic [8:0] y_sum, y_clip;

   always_comb begin
      accept   = bus.cmd_valid && (state_q == IDLE);
      x_sum    = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
      y_sum    = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
      x_clip   = (x_sum > W10) ? W10 : x_sum;
      y_clip   = (y_sum > H9) ? H9 : y_sum;
      empty    = (bus.cmd_w == 9'd0) || (bus.cmd_h == 8'd0) ||
                 ({1'b0, bus.cmd_x} >= W10) || ({1'b0, bus.cmd_y} >= H9);
      // Only a genuine high-to-low transition counts, so a vsync already low at accept is ignored.
      vs_fall  = vs_prev_q && !vs_q;
      last_col = ({1'b0, x_q} == (xe_q - 10'd1));
      last_row = ({1'b0, y_q} == (ye_q - 9'd1));
   end

   // State register
   always_ff @(posedge clk_vga) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         color_q   <= '0;
         xs_q      <= '0;
         ys_q      <= '0;
         col_q     <= '0;
         xe_q      <= '0;
         ye_q      <= '0;
         done_q    <= 1'b0;
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         color_q   <= color_d;
         xs_q      <= xs_d;
         ys_q      <= ys_d;
         col_q     <= col_d;
         xe_q      <= xe_d;
         ye_q      <= ye_d;
         done_q    <= done_d;
         vs_q      <= vga_vsync;
         vs_prev_q <= vs_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && !empty)
               state_d = (SYNC_TO_VBLANK != 0) ? WAIT_VB : DRAW;
         end
         WAIT_VB: begin
            if (vs_fall)
               state_d = DRAW;
         end
         DRAW: begin
            if (last_col && last_row)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Command latch and pixel walk
   always_comb begin
      xs_d    = xs_q;
      ys_d    = ys_q;
      col_d   = col_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      x_d     = x_q;
      y_d     = y_q;
      color_d = color_q;
      done_d  = (accept && empty) || ((state_q == DRAW) && last_col && last_row);

      if (accept) begin
         xs_d  = bus.cmd_x;
         ys_d  = bus.cmd_y;
         col_d = bus.cmd_color;
         xe_d  = x_clip;
         ye_d  = y_clip;
      end

      // Write-port registers only move when drawing starts or advances, so they hold while idle.
      if ((state_q == IDLE) && (state_d == DRAW)) begin
         x_d     = bus.cmd_x;
         y_d     = bus.cmd_y;
         color_d = bus.cmd_color;
      end else if ((state_q == WAIT_VB) && (state_d == DRAW)) begin
         x_d     = xs_q;
         y_d     = ys_q;
         color_d = col_q;
      end else if ((state_q == DRAW) && (state_d == DRAW)) begin
         if (last_col) begin
            x_d = xs_q;
            y_d = y_q + 8'd1;
         end else begin
            x_d = x_q + 9'd1;
         end
      end
   end

   // Outputs
   always_comb begin
      bus.cmd_ready = (state_q == IDLE);
      bus.wr_en     = (state_q == DRAW);
      bus.busy      = (state_q != IDLE);
      bus.x         = x_q;
      bus.y         = y_q;
      bus.color     = color_q;
      bus.done      = done_q;
   end

endmodule
